// File: rtl/prog_ram_pkg.sv
// Shared types and default geometry for the program RAM and its loader.
// Optional checksum feature is enabled by defining PROG_RAM_CHECKSUM_EN.
package prog_ram_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } prog_state_t;

endpackage

// File: rtl/prog_ram_if.sv
// Program-load stream interface: control, valid/ready data stream and status.
// prog_sum exists only when PROG_RAM_CHECKSUM_EN is defined.
interface prog_ram_if
    import prog_ram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              prog_mode;
    logic              prog_start;
    logic [ADDR_W-1:0] prog_base;
    logic [ADDR_W-1:0] prog_len;
    logic              prog_valid;
    logic [DATA_W-1:0] prog_data;
    logic              prog_ready;
    logic              prog_busy;
    logic              prog_done;
`ifdef PROG_RAM_CHECKSUM_EN
    logic [DATA_W-1:0] prog_sum;
`endif

    modport master (
        output prog_mode, prog_start, prog_base, prog_len, prog_valid, prog_data,
`ifdef PROG_RAM_CHECKSUM_EN
        input  prog_sum,
`endif
        input  prog_ready, prog_busy, prog_done
    );

    modport slave (
        input  prog_mode, prog_start, prog_base, prog_len, prog_valid, prog_data,
`ifdef PROG_RAM_CHECKSUM_EN
        output prog_sum,
`endif
        output prog_ready, prog_busy, prog_done
    );

endinterface

// File: rtl/prog_ram_loader.sv
// Auto-incrementing program-load FSM driving the RAM write port from a valid/ready stream.
// Running checksum of loaded words is present when PROG_RAM_CHECKSUM_EN is defined.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | waiting for prog_start while prog_mode=1
// ST_LOAD | ready asserted, each handshake writes mem[ptr] and advances
// ST_DONE | len words written, holds until prog_mode drops
module prog_loader
    import prog_ram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    prog_ram_if.slave         pif,
    output logic              ld_we_o,
    output logic [ADDR_W-1:0] ld_addr_o,
    output logic [DATA_W-1:0] ld_data_o
);
    localparam int                CNT_W   = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(1 << ADDR_W);

    prog_state_t       state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  len_q;
    logic              ready_q;
    logic              busy_q;
    logic              done_q;
    logic              hs;
`ifdef PROG_RAM_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;
`endif

    // Gating with prog_mode keeps a loader write from ever meeting a CPU write.
    assign hs = (state_q == ST_LOAD) && pif.prog_mode && pif.prog_valid && ready_q;

    assign ld_we_o        = hs;
    assign ld_addr_o      = ptr_q;
    assign ld_data_o      = pif.prog_data;
    assign pif.prog_ready = ready_q;
    assign pif.prog_busy  = busy_q;
    assign pif.prog_done  = done_q;
`ifdef PROG_RAM_CHECKSUM_EN
    assign pif.prog_sum   = sum_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef PROG_RAM_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pif.prog_mode && pif.prog_start) begin
                        state_q <= ST_LOAD;
                        ptr_q   <= pif.prog_base;
                        cnt_q   <= '0;
                        len_q   <= (pif.prog_len == '0) ? DEPTH_C : CNT_W'(pif.prog_len);
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
`ifdef PROG_RAM_CHECKSUM_EN
                        sum_q   <= '0;
`endif
                    end
                end
                ST_LOAD: begin
                    if (!pif.prog_mode) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (hs) begin
                        ptr_q <= ptr_q + 1'b1;
                        cnt_q <= cnt_q + 1'b1;
`ifdef PROG_RAM_CHECKSUM_EN
                        sum_q <= sum_q + pif.prog_data;
`endif
                        if (cnt_q == len_q - CNT_W'(1)) begin
                            state_q <= ST_DONE;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (!pif.prog_mode) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/prog_ram.sv
// DEPTH x DATA_W RAM with a CPU read/write port and a streaming program-load port.
// Define PROG_RAM_CHECKSUM_EN to expose the loader checksum on pif.prog_sum.
module prog_ram
    import prog_ram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    prog_ram_if.slave         pif,
    input  logic              w_en_i,
    input  logic [ADDR_W-1:0] address_i,
    input  logic [DATA_W-1:0] w_data_i,
    output logic [DATA_W-1:0] r_data_o
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              cpu_we;

    prog_loader #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_loader (
        .clk       (clk),
        .rst       (rst),
        .pif       (pif),
        .ld_we_o   (ld_we),
        .ld_addr_o (ld_addr),
        .ld_data_o (ld_data)
    );

    assign cpu_we = w_en_i && !pif.prog_mode;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (ld_we) begin
            mem_q[ld_addr] <= ld_data;
        end else if (cpu_we) begin
            mem_q[address_i] <= w_data_i;
        end
    end

    assign r_data_o = mem_q[address_i];

endmodule

// File: tb/tb_prog_ram.sv
// Directed bench for prog_ram: CPU vector table plus load, wrap, abort and checksum sequences.
module tb_prog_ram;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk;
    logic          rst;
    logic          w_en;
    logic [AW-1:0] address;
    logic [DW-1:0] w_data;
    logic [DW-1:0] r_data;

    int checks;
    int errors;

    prog_ram_if #(.DATA_W(DW), .ADDR_W(AW)) pif ();

    prog_ram #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .pif       (pif),
        .w_en_i    (w_en),
        .address_i (address),
        .w_data_i  (w_data),
        .r_data_o  (r_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          w_en;
        logic          mode;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } cpu_vec_t;

    cpu_vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_check(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        address = a;
        #1;
        check(name, 32'(r_data), 32'(exp));
    endtask

    task automatic start_load(input logic [AW-1:0] base, input logic [AW-1:0] len);
        pif.prog_base  = base;
        pif.prog_len   = len;
        pif.prog_start = 1'b1;
        tick();
        pif.prog_start = 1'b0;
    endtask

    task automatic send_word(input logic [DW-1:0] d, input int gap);
        pif.prog_valid = 1'b0;
        for (int g = 0; g < gap; g++) tick();
        check("ready_before_hs", 32'(pif.prog_ready), 32'd1);
        pif.prog_valid = 1'b1;
        pif.prog_data  = d;
        tick();
        pif.prog_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        w_en = 1'b0;
        address = '0;
        w_data = '0;
        pif.prog_mode  = 1'b0;
        pif.prog_start = 1'b0;
        pif.prog_base  = '0;
        pif.prog_len   = '0;
        pif.prog_valid = 1'b0;
        pif.prog_data  = '0;

        vecs[0] = '{1'b1, 1'b0, 4'h3, 8'hA5, 8'hA5};
        vecs[1] = '{1'b1, 1'b1, 4'h3, 8'h5A, 8'hA5};
        vecs[2] = '{1'b1, 1'b0, 4'h7, 8'h3C, 8'h3C};
        vecs[3] = '{1'b0, 1'b0, 4'h3, 8'hFF, 8'hA5};
        vecs[4] = '{1'b1, 1'b0, 4'hF, 8'hC3, 8'hC3};
        vecs[5] = '{1'b0, 1'b1, 4'h7, 8'h00, 8'h3C};
        vecs[6] = '{1'b1, 1'b0, 4'h3, 8'h00, 8'h00};

        #12;
        rst = 1'b0;
        tick();
        check("rst_ready", 32'(pif.prog_ready), 32'd0);
        check("rst_busy",  32'(pif.prog_busy),  32'd0);
        check("rst_done",  32'(pif.prog_done),  32'd0);
        read_check("rst_mem0", 4'h0, 8'h00);

        // CPU port vectors
        foreach (vecs[i]) begin
            w_en          = vecs[i].w_en;
            pif.prog_mode = vecs[i].mode;
            address       = vecs[i].addr;
            w_data        = vecs[i].wdata;
            tick();
            check($sformatf("cpu_vec%0d", i), 32'(r_data), 32'(vecs[i].exp_rdata));
        end
        w_en = 1'b0;
        pif.prog_mode = 1'b0;

        // Fill every word, then async reset must clear all of them
        for (int a = 0; a < 16; a++) begin
            w_en = 1'b1;
            address = 4'(a);
            w_data = 8'(8'h80 + a);
            tick();
        end
        w_en = 1'b0;
        read_check("fill_mem9", 4'h9, 8'h89);
        #2 rst = 1'b1;
        #1;
        check("async_rst_immediate", 32'(r_data), 32'd0);
        rst = 1'b0;
        for (int a = 0; a < 16; a++) read_check($sformatf("rst_clear%0d", a), 4'(a), 8'h00);
        check("rst2_ready", 32'(pif.prog_ready), 32'd0);

        // Load base=2 len=3 with valid gaps; stray start in LOAD is ignored
        pif.prog_mode = 1'b1;
        start_load(4'h2, 4'h3);
        check("load_busy", 32'(pif.prog_busy), 32'd1);
        check("load_done0", 32'(pif.prog_done), 32'd0);
        send_word(8'h11, 1);
        pif.prog_base = 4'h9;
        pif.prog_start = 1'b1;
        tick();
        pif.prog_start = 1'b0;
        send_word(8'h22, 2);
        check("load_busy_mid", 32'(pif.prog_busy), 32'd1);
        send_word(8'h33, 0);
        check("load_done", 32'(pif.prog_done), 32'd1);
        check("load_busy_end", 32'(pif.prog_busy), 32'd0);
        check("load_ready_end", 32'(pif.prog_ready), 32'd0);
        tick();
        check("done_holds", 32'(pif.prog_done), 32'd1);
        pif.prog_mode = 1'b0;
        tick();
        check("done_cleared", 32'(pif.prog_done), 32'd0);
        read_check("load_mem2", 4'h2, 8'h11);
        read_check("load_mem3", 4'h3, 8'h22);
        read_check("load_mem4", 4'h4, 8'h33);
        read_check("load_mem5", 4'h5, 8'h00);
        read_check("load_mem9", 4'h9, 8'h00);

        // Full-depth load wrapping from 0xE
        pif.prog_mode = 1'b1;
        start_load(4'hE, 4'h0);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) check("wrap_busy_pre16", 32'(pif.prog_busy), 32'd1);
            send_word(8'(i), i % 3 == 0 ? 1 : 0);
        end
        check("wrap_done", 32'(pif.prog_done), 32'd1);
        pif.prog_mode = 1'b0;
        tick();
        for (int i = 0; i < 16; i++)
            read_check($sformatf("wrap_mem%0h", (i + 14) % 16), 4'((i + 14) % 16), 8'(i));

        // Abort after 2 of 4 words
        pif.prog_mode = 1'b1;
        start_load(4'h0, 4'h4);
        send_word(8'hC0, 0);
        send_word(8'hC1, 1);
        pif.prog_mode = 1'b0;
        tick();
        check("abort_busy", 32'(pif.prog_busy), 32'd0);
        check("abort_ready", 32'(pif.prog_ready), 32'd0);
        check("abort_done", 32'(pif.prog_done), 32'd0);
        read_check("abort_mem0", 4'h0, 8'hC0);
        read_check("abort_mem1", 4'h1, 8'hC1);
        read_check("abort_mem2", 4'h2, 8'h04);
        read_check("abort_mem3", 4'h3, 8'h05);
        start_load(4'h0, 4'h4);
        check("start_no_mode_busy", 32'(pif.prog_busy), 32'd0);
        check("start_no_mode_ready", 32'(pif.prog_ready), 32'd0);

`ifdef PROG_RAM_CHECKSUM_EN
        pif.prog_mode = 1'b1;
        start_load(4'h8, 4'h2);
        check("sum_start", 32'(pif.prog_sum), 32'd0);
        send_word(8'hFF, 0);
        send_word(8'h02, 1);
        check("sum_done", 32'(pif.prog_sum), 32'h01);
        pif.prog_mode = 1'b0;
        tick();
        check("sum_idle_hold", 32'(pif.prog_sum), 32'h01);
        pif.prog_mode = 1'b1;
        start_load(4'h8, 4'h1);
        check("sum_restart", 32'(pif.prog_sum), 32'h00);
        pif.prog_mode = 1'b0;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
